// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART definitions: receiver state encodings, the parity sense, and a
// ceil-log2 helper used to size counters (also used by the TX side).
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } rx_state_e;

  // Even parity: XOR of data and parity bit must come out 0.
  localparam logic EVEN_PARITY = 1'b0;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int v;
    int w;
    v = value - 1;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((v >> i) != 0) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-period counter for the UART receiver. Counts while enabled, wraps to 0
// at BIT_CNT-1, and flags the half-period and full-period points.
module uart_baud_cnt
  import uart_rx_ctrl_pkg::*;
#(
  parameter int BIT_CNT = 434,
  parameter int HALF    = 217,
  parameter int CNT_W   = clog2(BIT_CNT)
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  input  logic en,
  output logic half_tick,
  output logic full_tick
);

  logic [CNT_W-1:0] cnt;

  // Ticks only count while the FSM is timing a bit.
  assign half_tick = en && (cnt == CNT_W'(HALF - 1));
  assign full_tick = en && (cnt == CNT_W'(BIT_CNT - 1));

  // Free-running bit timer; clear wins over count, wrap at the end of a bit.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)          cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (full_tick) cnt <= '0;
    else if (en)        cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller. A one-cycle h2l_sig pulse in IDLE starts a
// frame; bits are sampled at mid-period, data shifted in LSB first, the stop
// bit checked, and the byte presented with a one-cycle rx_done pulse.
// Optional parity bit and parity_err port: define UART_RX_PARITY_EN.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 rx_pin_in,
  input  logic                 h2l_sig,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int BIT_CNT = CLK_FREQ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CNT_W   = clog2(BIT_CNT);
  localparam int IDX_W   = clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  localparam rx_state_e ST_AFTER_DATA = ST_PARITY;
`else
  localparam rx_state_e ST_AFTER_DATA = ST_STOP;
`endif

  rx_state_e            state, state_nxt;
  logic                 cnt_clr, cnt_en;
  logic                 half_tick, full_tick;
  logic                 shift_en, load_en;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic                 par_en;
  logic                 par_bit;
`endif

  uart_baud_cnt #(
    .BIT_CNT (BIT_CNT),
    .HALF    (HALF),
    .CNT_W   (CNT_W)
  ) u_baud (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and datapath strobes; rx_en low overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    shift_en  = 1'b0;
    load_en   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    if (!rx_en) begin
      state_nxt = ST_IDLE;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_clr = 1'b1;
          if (h2l_sig) state_nxt = ST_START;
        end
        ST_START: begin
          cnt_en = 1'b1;
          if (half_tick) begin
            // Line back high at mid-start: treat the edge as a glitch.
            cnt_clr   = 1'b1;
            state_nxt = rx_pin_in ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          cnt_en = 1'b1;
          if (full_tick) begin
            shift_en = 1'b1;
            if (idx == LAST_IDX) state_nxt = ST_AFTER_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          cnt_en = 1'b1;
          if (full_tick) begin
            par_en    = 1'b1;
            state_nxt = ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          cnt_en = 1'b1;
          // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
          if (full_tick) begin
            load_en   = 1'b1;
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          cnt_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: begin
          cnt_clr   = 1'b1;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Shift register, bit index and output registers; outputs change only on load.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      idx        <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      if (state == ST_START) idx <= '0;
      if (shift_en) begin
        shreg[idx] <= rx_pin_in;
        idx        <= idx + IDX_W'(1);
      end
`ifdef UART_RX_PARITY_EN
      if (par_en) par_bit <= rx_pin_in;
`endif
      if (load_en) begin
        rx_data    <= shreg;
        frame_err  <= ~rx_pin_in;
`ifdef UART_RX_PARITY_EN
        parity_err <= ((^shreg) ^ par_bit) != EVEN_PARITY;
`endif
      end
    end
  end

  // DONE lasts exactly one cycle, so the pulse is just the state decode.
  assign rx_done = (state == ST_DONE);

endmodule
